// File: rtl/dmni_br_rx.sv
// dmni_br_rx: receive side of the BrLite broadcast path into the DMNI.
// Broadcast payloads from the router are queued in a circular buffer and
// handed to the CPU through two read-only registers. KSVC (0x40) peeks at the
// head entry. PAYLOAD (0x44) returns the head entry and pops it.
module dmni_br_rx #(
  parameter int unsigned BR_BUFSZ = 8,
  localparam int unsigned PW = (BR_BUFSZ > 1) ? $clog2(BR_BUFSZ) : 1,
  localparam int unsigned CW = $clog2(BR_BUFSZ) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          br_req_i,
  output logic          br_ack_o,
  input  logic [35:0]   br_data_i,
  input  logic          cfg_en_i,
  input  logic          cfg_we_i,
  input  logic [7:0]    cfg_addr_i,
  output logic [31:0]   cfg_data_o,
  output logic          br_pending_o,
  output logic [CW-1:0] br_count_o
);

  localparam logic [7:0] ADDR_KSVC    = 8'h40;
  localparam logic [7:0] ADDR_PAYLOAD = 8'h44;

  // Entry layout, msb to lsb: payload[15:0], seq_source[15:0], ksvc[3:0].
  function automatic logic [31:0] entry_ksvc(input logic [35:0] e);
    return {28'h0000000, e[3:0]};
  endfunction

  // The PAYLOAD register presents the data as {seq_source, payload}.
  function automatic logic [31:0] entry_payload(input logic [35:0] e);
    return {e[19:4], e[35:20]};
  endfunction

  logic [35:0]   mem_q [BR_BUFSZ];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic        full_s;
  logic        empty_s;
  logic        push_s;
  logic        pop_s;
  logic        rd_acc_s;
  logic        ksvc_sel_s;
  logic        pay_sel_s;
  logic [35:0] head_s;

  // Full uses the occupancy register, so a pop in the same cycle cannot
  // free a slot for a push until the next cycle.
  assign full_s     = (count_q == CW'(BR_BUFSZ));
  assign empty_s    = (count_q == CW'(0));
  assign rd_acc_s   = cfg_en_i & ~cfg_we_i;
  assign ksvc_sel_s = rd_acc_s & (cfg_addr_i == ADDR_KSVC);
  assign pay_sel_s  = rd_acc_s & (cfg_addr_i == ADDR_PAYLOAD);
  assign head_s     = mem_q[rd_ptr_q];

  // Ack is gated by rst_ni so that the router never sees an accept during reset.
  assign push_s       = rst_ni & br_req_i & ~full_s;
  assign pop_s        = pay_sel_s & ~empty_s;
  assign br_ack_o     = push_s;
  assign br_pending_o = (count_q != CW'(0));
  assign br_count_o   = count_q;

  // Register read mux. An empty buffer reads as zero.
  always_comb begin
    cfg_data_o = 32'h00000000;
    if (empty_s) begin
      cfg_data_o = 32'h00000000;
    end else if (ksvc_sel_s) begin
      cfg_data_o = entry_ksvc(head_s);
    end else if (pay_sel_s) begin
      cfg_data_o = entry_payload(head_s);
    end else begin
      cfg_data_o = 32'h00000000;
    end
  end

  // Next-state computation for the pointers and the occupancy counter.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers. Reset discards all entries at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage. Contents are not reset because the pointers make them invisible.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= br_data_i;
    end
  end

endmodule

// File: tb/tb_dmni_br_rx.sv
// Directed bench for dmni_br_rx (BR_BUFSZ = 8).
module tb_dmni_br_rx;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        br_req_i;
  logic        br_ack_o;
  logic [35:0] br_data_i;
  logic        cfg_en_i;
  logic        cfg_we_i;
  logic [7:0]  cfg_addr_i;
  logic [31:0] cfg_data_o;
  logic        br_pending_o;
  logic [3:0]  br_count_o;

  int n_vec = 0;
  int n_err = 0;

  dmni_br_rx #(.BR_BUFSZ(8)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .br_req_i    (br_req_i),
    .br_ack_o    (br_ack_o),
    .br_data_i   (br_data_i),
    .cfg_en_i    (cfg_en_i),
    .cfg_we_i    (cfg_we_i),
    .cfg_addr_i  (cfg_addr_i),
    .cfg_data_o  (cfg_data_o),
    .br_pending_o(br_pending_o),
    .br_count_o  (br_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entry i carries payload 0x1000+i, seq_source 0x2000+i, ksvc i[3:0].
  function automatic logic [35:0] mk(input int i);
    logic [15:0] p;
    logic [15:0] s;
    p = 16'h1000 + 16'(i);
    s = 16'h2000 + 16'(i);
    return {p, s, 4'(i)};
  endfunction

  function automatic logic [31:0] pay(input int i);
    logic [15:0] p;
    logic [15:0] s;
    p = 16'h1000 + 16'(i);
    s = 16'h2000 + 16'(i);
    return {s, p};
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    br_req_i   = 1'b0;
    cfg_en_i   = 1'b0;
    cfg_we_i   = 1'b0;
    cfg_addr_i = 8'h00;
  endtask

  task automatic push(input logic [35:0] d);
    br_req_i  = 1'b1;
    br_data_i = d;
    #1;
    check("push_ack", {35'd0, br_ack_o}, 36'd1);
    step();
    br_req_i = 1'b0;
  endtask

  task automatic pop(input string tag, input logic [31:0] exp);
    cfg_en_i   = 1'b1;
    cfg_we_i   = 1'b0;
    cfg_addr_i = 8'h44;
    #1;
    check(tag, {4'h0, cfg_data_o}, {4'h0, exp});
    step();
    cfg_en_i = 1'b0;
  endtask

  task automatic rd(input string tag, input logic we, input logic [7:0] addr,
                    input logic en, input logic [31:0] exp);
    cfg_en_i   = en;
    cfg_we_i   = we;
    cfg_addr_i = addr;
    #1;
    check(tag, {4'h0, cfg_data_o}, {4'h0, exp});
    cfg_en_i = 1'b0;
    cfg_we_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    br_data_i = 36'h0;
    rst_ni    = 1'b0;
    br_req_i  = 1'b1;
    #12;
    check("rst_ack", {35'd0, br_ack_o}, 36'd0);
    check("rst_count", {32'd0, br_count_o}, 36'd0);
    check("rst_pending", {35'd0, br_pending_o}, 36'd0);
    br_req_i = 1'b0;
    rst_ni   = 1'b1;
    step();

    // Basic push, peek, pop.
    push(36'hABCD_0012_5);
    #1;
    check("one_count", {32'd0, br_count_o}, 36'd1);
    check("one_pending", {35'd0, br_pending_o}, 36'd1);
    rd("ksvc_read", 1'b0, 8'h40, 1'b1, 32'h00000005);
    step();
    check("ksvc_nopop", {32'd0, br_count_o}, 36'd1);
    pop("pay_read", 32'h0012ABCD);
    #1;
    check("drain_count", {32'd0, br_count_o}, 36'd0);
    check("drain_pending", {35'd0, br_pending_o}, 36'd0);
    step();

    // Fill past capacity: exactly 8 acks.
    for (int i = 0; i < 10; i++) begin
      br_req_i  = 1'b1;
      br_data_i = mk(i);
      #1;
      check($sformatf("fill_ack%0d", i), {35'd0, br_ack_o}, (i < 8) ? 36'd1 : 36'd0);
      step();
    end
    check("full_count", {32'd0, br_count_o}, 36'd8);

    // Full with push and pop together: no ack this cycle.
    br_data_i  = 36'h5A5A_0077_3;
    cfg_en_i   = 1'b1;
    cfg_addr_i = 8'h44;
    #1;
    check("fullpop_ack", {35'd0, br_ack_o}, 36'd0);
    check("fullpop_data", {4'h0, cfg_data_o}, {4'h0, pay(0)});
    step();
    cfg_en_i = 1'b0;
    #1;
    check("fullpop_count", {32'd0, br_count_o}, 36'd7);
    check("refill_ack", {35'd0, br_ack_o}, 36'd1);
    step();
    br_req_i = 1'b0;
    #1;
    check("refill_count", {32'd0, br_count_o}, 36'd8);
    for (int i = 1; i < 8; i++) pop($sformatf("order%0d", i), pay(i));
    pop("order_last", 32'h0077_5A5A);
    check("order_empty", {32'd0, br_count_o}, 36'd0);

    // Occupancy 3 with simultaneous push and pop.
    push(mk(20));
    push(mk(21));
    push(mk(22));
    br_req_i   = 1'b1;
    br_data_i  = mk(23);
    cfg_en_i   = 1'b1;
    cfg_addr_i = 8'h44;
    #1;
    check("pp_ack", {35'd0, br_ack_o}, 36'd1);
    check("pp_data", {4'h0, cfg_data_o}, {4'h0, pay(20)});
    step();
    idle();
    check("pp_count", {32'd0, br_count_o}, 36'd3);
    pop("pp_b", pay(21));
    pop("pp_c", pay(22));
    pop("pp_d", pay(23));

    // Decode: other addresses, writes and idle strobe read zero and do not pop.
    push(mk(30));
    rd("dec_addr", 1'b0, 8'h48, 1'b1, 32'h0);
    rd("dec_we", 1'b1, 8'h44, 1'b1, 32'h0);
    rd("dec_en", 1'b0, 8'h44, 1'b0, 32'h0);
    rd("dec_we40", 1'b1, 8'h40, 1'b1, 32'h0);
    step();
    check("dec_count", {32'd0, br_count_o}, 36'd1);
    pop("dec_pop", pay(30));

    // Empty reads return zero and leave the buffer alone.
    rd("empty_pay", 1'b0, 8'h44, 1'b1, 32'h0);
    rd("empty_ksvc", 1'b0, 8'h40, 1'b1, 32'h0);
    step();
    check("empty_count", {32'd0, br_count_o}, 36'd0);
    push(mk(31));
    rd("after_ksvc", 1'b0, 8'h40, 1'b1, 32'h0000000F);
    pop("after_pay", pay(31));

    // Twenty push/pop cycles through the pointer wrap.
    push(mk(40));
    for (int i = 0; i < 20; i++) begin
      br_req_i   = 1'b1;
      br_data_i  = mk(41 + i);
      cfg_en_i   = 1'b1;
      cfg_addr_i = 8'h44;
      #1;
      check($sformatf("wrap%0d", i), {4'h0, cfg_data_o}, {4'h0, pay(40 + i)});
      step();
    end
    cfg_en_i  = 1'b0;
    br_data_i = mk(99);
    #1;
    check("wrap_count", {32'd0, br_count_o}, 36'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("mid_rst_ack", {35'd0, br_ack_o}, 36'd0);
    check("mid_rst_count", {32'd0, br_count_o}, 36'd0);
    check("mid_rst_pending", {35'd0, br_pending_o}, 36'd0);
    #2;
    br_req_i = 1'b0;
    rst_ni   = 1'b1;
    step();
    push(mk(50));
    rd("post_rst_ksvc", 1'b0, 8'h40, 1'b1, 32'h00000002);
    pop("post_rst_pay", pay(50));
    check("post_rst_count", {32'd0, br_count_o}, 36'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
